seq_sub: RTL and testbench



---
 rtl/seq_sub.sv | 114 +++++++++++
 tb/tb_seq_sub.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_sub.sv
// Multi-cycle subtractor: res = a - b - bin (mod 2^N), K bits per clock.
// Operands shift right by K each chunk while result chunks shift in from the top.
module seq_sub #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res,
    output logic         bout,
    output logic         overflow,
    output logic         zero,
    output logic         neg
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int NC = N / K;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NC - 1);

    state_t        state_q;
    logic [CW-1:0] i_q;
    logic [N-1:0]  a_q, b_q, res_q;
    logic          a_msb_q, b_msb_q, carry_q;
    logic          busy_q, done_q, bout_q, ovf_q, zero_q, neg_q;

    logic [K:0]    sum;
    logic [N-1:0]  res_d;

    // Subtraction as a + ~b + carry, where carry starts as ~bin.
    assign sum = {1'b0, a_q[K-1:0]} + {1'b0, ~b_q[K-1:0]} + {{K{1'b0}}, carry_q};

    generate
        if (K == N) begin : g_single
            assign res_d = sum[K-1:0];
        end else begin : g_multi
            assign res_d = {sum[K-1:0], res_q[N-1:K]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            carry_q <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        a_msb_q <= a[N-1];
                        b_msb_q <= b[N-1];
                        carry_q <= ~bin;
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= sum[K];
                    a_q     <= a_q >> K;
                    b_q     <= b_q >> K;
                    if (i_q == LAST) begin
                        // Sign bits were captured at start since a_q/b_q are shifted away.
                        i_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= ~sum[K];
                        ovf_q   <= (a_msb_q != b_msb_q) && (res_d[N-1] != a_msb_q);
                        zero_q  <= (res_d == '0);
                        neg_q   <= res_d[N-1];
                        state_q <= S_DONE;
                    end else begin
                        i_q <= i_q + CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res      = res_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign neg      = neg_q;

endmodule

// File: tb/tb_seq_sub.sv
// Bench for seq_sub: directed cases on the default configuration plus
// random sweeps on three other N/K configurations against an arithmetic model.
module tb_seq_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        st0, bi0, by0, dn0, bo0, ov0, z0, ng0;
    logic [31:0] a0, b0, r0;
    logic        st1, bi1, by1, dn1, bo1, ov1, z1, ng1;
    logic [31:0] a1, b1, r1;
    logic        st2, bi2, by2, dn2, bo2, ov2, z2, ng2;
    logic [7:0]  a2, b2, r2;
    logic        st3, bi3, by3, dn3, bo3, ov3, z3, ng3;
    logic [15:0] a3, b3, r3;

    seq_sub #(.N(32), .K(8)) u0 (.clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .bin(bi0),
        .busy(by0), .done(dn0), .res(r0), .bout(bo0), .overflow(ov0), .zero(z0), .neg(ng0));
    seq_sub #(.N(32), .K(32)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .bin(bi1),
        .busy(by1), .done(dn1), .res(r1), .bout(bo1), .overflow(ov1), .zero(z1), .neg(ng1));
    seq_sub #(.N(8), .K(1)) u2 (.clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .bin(bi2),
        .busy(by2), .done(dn2), .res(r2), .bout(bo2), .overflow(ov2), .zero(z2), .neg(ng2));
    seq_sub #(.N(16), .K(4)) u3 (.clk(clk), .rst_n(rst_n), .start(st3), .a(a3), .b(b3), .bin(bi3),
        .busy(by3), .done(dn3), .res(r3), .bout(bo3), .overflow(ov3), .zero(z3), .neg(ng3));

    int total = 0;
    int bad   = 0;

    function automatic int nbits(int cfg);
        case (cfg)
            0: return 32;
            1: return 32;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int kbits(int cfg);
        case (cfg)
            0: return 8;
            1: return 32;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int n, input logic [31:0] av, input logic [31:0] bv, input logic bi,
                         output logic [31:0] r, output logic bo, output logic ov,
                         output logic z, output logic ng);
        longint mask, au, bu, bl, d, half, sa, sb, sd;
        mask = (longint'(1) << n) - 1;
        au   = longint'(av) & mask;
        bu   = longint'(bv) & mask;
        bl   = bi ? 1 : 0;
        d    = au - bu - bl;
        r    = 32'(d & mask);
        bo   = (au < bu + bl);
        half = longint'(1) << (n - 1);
        sa   = (au >= half) ? au - (longint'(1) << n) : au;
        sb   = (bu >= half) ? bu - (longint'(1) << n) : bu;
        sd   = sa - sb - bl;
        ov   = (sd < -half) || (sd >= half);
        z    = (r == 32'd0);
        ng   = (((longint'(r) >> (n - 1)) & 1) != 0);
    endtask

    task automatic drive(int cfg, logic s, logic [31:0] av, logic [31:0] bv, logic bi);
        case (cfg)
            0: begin st0 = s; a0 = av;        b0 = bv;        bi0 = bi; end
            1: begin st1 = s; a1 = av;        b1 = bv;        bi1 = bi; end
            2: begin st2 = s; a2 = av[7:0];   b2 = bv[7:0];   bi2 = bi; end
            default: begin st3 = s; a3 = av[15:0]; b3 = bv[15:0]; bi3 = bi; end
        endcase
    endtask

    task automatic sample(int cfg, output logic by, output logic dn, output logic [31:0] r,
                          output logic bo, output logic ov, output logic z, output logic ng);
        case (cfg)
            0: begin by = by0; dn = dn0; r = r0;          bo = bo0; ov = ov0; z = z0; ng = ng0; end
            1: begin by = by1; dn = dn1; r = r1;          bo = bo1; ov = ov1; z = z1; ng = ng1; end
            2: begin by = by2; dn = dn2; r = {24'd0, r2}; bo = bo2; ov = ov2; z = z2; ng = ng2; end
            default: begin by = by3; dn = dn3; r = {16'd0, r3}; bo = bo3; ov = ov3; z = z3; ng = ng3; end
        endcase
    endtask

    // One full operation; poke re-asserts start with other operands mid-run.
    task automatic run_op(int cfg, logic [31:0] av, logic [31:0] bv, logic bi, bit poke, string tag);
        logic [31:0] er, r;
        logic        eb, eo, ez, en, by, dn, bo, ov, z, ng;
        int          n, nc, cyc;
        bit          got, busy_ok;
        n  = nbits(cfg);
        nc = n / kbits(cfg);
        model(n, av, bv, bi, er, eb, eo, ez, en);

        @(negedge clk);
        drive(cfg, 1'b1, av, bv, bi);
        @(posedge clk);
        #1;
        drive(cfg, 1'b0, $urandom, $urandom, 1'($urandom));
        sample(cfg, by, dn, r, bo, ov, z, ng);
        chk({tag, "_busy_e0"}, 64'(by), 64'd1);

        cyc = 0; got = 0; busy_ok = 1;
        while (!got && cyc < 100) begin
            if (poke && cyc == 1) drive(cfg, 1'b1, 32'd7, 32'd7, 1'b0);
            else if (poke && cyc == 2) drive(cfg, 1'b0, 32'd7, 32'd7, 1'b0);
            @(posedge clk);
            #1;
            cyc++;
            sample(cfg, by, dn, r, bo, ov, z, ng);
            if (dn) got = 1;
            else if (!by) busy_ok = 0;
        end
        // done visible after edge cyc, i.e. sampled high at edge E(cyc+1).
        chk({tag, "_latency"}, 64'(cyc), 64'(nc));
        chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(by), 64'd0);
        chk({tag, "_res"}, 64'(r), 64'(er));
        chk({tag, "_bout"}, 64'(bo), 64'(eb));
        chk({tag, "_ovf"}, 64'(ov), 64'(eo));
        chk({tag, "_zero"}, 64'(z), 64'(ez));
        chk({tag, "_neg"}, 64'(ng), 64'(en));

        @(posedge clk);
        #1;
        sample(cfg, by, dn, r, bo, ov, z, ng);
        chk({tag, "_done_pulse"}, 64'(dn), 64'd0);
        chk({tag, "_res_hold"}, 64'(r), 64'(er));
    endtask

    initial begin
        logic [31:0] av, bv, r;
        logic        by, dn, bo, ov, z, ng;
        bit          no_done;

        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) drive(c, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            sample(c, by, dn, r, bo, ov, z, ng);
            chk("rst_outputs", {57'd0, by, dn, bo, ov, z, ng, |r}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 32'd5, 32'd3, 1'b0, 0, "d_5m3");
        chk("d_5m3_const", 64'(r0), 64'd2);
        run_op(0, 32'd0, 32'd1, 1'b0, 0, "d_0m1");
        chk("d_0m1_const", 64'(r0), 64'hFFFF_FFFF);
        run_op(0, 32'h8000_0000, 32'd1, 1'b0, 0, "d_minm1");
        chk("d_minm1_ovf_const", 64'(ov0), 64'd1);
        run_op(0, 32'h1234_5678, 32'h1234_5677, 1'b1, 0, "d_zero");
        chk("d_zero_const", 64'(z0), 64'd1);
        run_op(0, 32'h0000_0100, 32'h0000_0001, 1'b0, 0, "d_xchunk");
        chk("d_xchunk_const", 64'(r0), 64'hFF);
        run_op(0, 32'd100, 32'd1, 1'b0, 1, "d_ignore_start");
        chk("d_ignore_const", 64'(r0), 64'd99);

        // Abort: rst_n low sampled at the edge after E2.
        @(negedge clk);
        drive(0, 1'b1, 32'd50, 32'd20, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sample(0, by, dn, r, bo, ov, z, ng);
        chk("abort_busy", 64'(by), 64'd0);
        chk("abort_done", 64'(dn), 64'd0);
        chk("abort_res", 64'(r), 64'd0);
        chk("abort_flags", {60'd0, bo, ov, z, ng}, 64'd0);
        rst_n = 1'b1;
        no_done = 1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (dn0 !== 1'b0 || by0 !== 1'b0) no_done = 0;
        end
        chk("abort_no_done", 64'(no_done), 64'd1);
        run_op(0, 32'd9, 32'd4, 1'b0, 0, "d_after_abort");
        chk("d_after_abort_const", 64'(r0), 64'd5);

        for (int c = 0; c < 4; c++) begin
            int iters;
            iters = (c == 0) ? 200 : 1000;
            for (int i = 0; i < iters; i++) begin
                av = $urandom;
                bv = $urandom;
                case ($urandom_range(0, 7))
                    0: av = 32'd0;
                    1: bv = 32'hFFFF_FFFF;
                    2: bv = av;
                    default: ;
                endcase
                run_op(c, av, bv, 1'($urandom), 0, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
